regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 integer register file between two requesters:
  - A: the pipeline writeback stage.
  - B: a multi-cycle mul/div unit.
- Fixed priority to A, with an aging counter that guarantees B a grant after a bounded wait.
- The write command (rf_we/rf_wa/rf_wd) is registered and drives the register file's per-register enable decode and data inputs.

Parameters:
- N, 32, data width.
- ADDR_W, 5, register address width.
- MAX_WAIT, 4, consecutive cycles B may be denied before it is forced to win (1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_valid  input  1  A has a write pending.
- wb_rd  input  ADDR_W  A destination register.
- wb_data  input  N  A write data.
- wb_ready  output  1  A request accepted this cycle (combinational).
- mdu_valid  input  1  B has a write pending.
- mdu_rd  input  ADDR_W  B destination register.
- mdu_data  input  N  B write data.
- mdu_ready  output  1  B request accepted this cycle (combinational).
- rf_we  output  1  register file write enable (registered).
- rf_wa  output  ADDR_W  register file write address (registered).
- rf_wd  output  N  register file write data (registered).
- b_forced  output  1  high while FORCE_B state is active.
- conflict_cnt  output  16  number of cycles with both requesters valid.

Behaviour:
- Reset (asserted asynchronously, released synchronously to clk):
  - rf_we=0, rf_wa=0, rf_wd=0, conflict_cnt=0, wait counter=0.
  - State = PRIO_A.
- Handshake:
  - A transfer occurs when valid && ready on a rising clk edge.
  - Requesters hold valid/rd/data stable until accepted.
  - At most one requester is accepted per cycle.
  - wb_ready and mdu_ready are never both 1.
- State PRIO_A:
  - If wb_valid: grant A.
  - Else if mdu_valid: grant B.
  - If mdu_valid && !mdu_ready: wait counter +1, saturating at MAX_WAIT.
  - When the counter reaches MAX_WAIT with B still denied, next state = FORCE_B.
- State FORCE_B:
  - If mdu_valid: grant B (A denied even if valid), clear the counter, return to PRIO_A.
  - If mdu_valid dropped: clear the counter, return to PRIO_A with no forced grant.
  - b_forced=1 only in this state.
- Any B grant in PRIO_A also clears the wait counter.
- Latency: a command accepted in cycle t appears on rf_we/rf_wa/rf_wd in cycle t+1, for exactly one cycle.
- With no acceptance in cycle t: rf_we=0 in t+1; rf_wa and rf_wd hold their previous values.
- Writes to x0 (rd==0):
  - Accepted normally; ready is asserted.
  - rf_we stays 0, so x0 is never written.
- Both requesters valid with the same rd: serialized in grant order. The later grant's value is the final register contents.
- conflict_cnt: +1 on every cycle with wb_valid && mdu_valid; saturates at 0xFFFF.
- Reset mid-operation: any pending output write is dropped (rf_we forced 0 immediately).

Optional Feature:
- RFARB_STATS_EN
  - Defined: conflict_cnt counts as described above.
  - Undefined: the counter logic is removed and conflict_cnt is tied to 0. Arbitration is otherwise identical.

Test Plan:
- Reset released; wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> wb_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
- wb_valid and mdu_valid both held high, MAX_WAIT=4:
  - A is granted for 4 cycles.
  - 5th cycle: b_forced=1, mdu_ready=1, wb_ready=0.
  - Then A resumes.
  - conflict_cnt = 5 (macro defined) or 0 (macro undefined).
- mdu_valid=1, mdu_rd=0, mdu_data=0x12345678, A idle -> mdu_ready=1; next cycle rf_we=0.
- Enter FORCE_B, then drop mdu_valid before the forced grant -> state returns to PRIO_A; wb_ready=1 next cycle; wait counter=0.
- Both requesters write rd=7 (A=0x1, B=0x2) simultaneously -> rf_wa=7 writes in two consecutive accepted cycles, A first (0x1) then B (0x2).
- Assert reset the cycle after an acceptance -> rf_we drops to 0 before the clock edge, with no write issued; all outputs equal their reset values.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register file write port arbiter with B aging
// Optional: define RFARB_STATS_EN to keep the conflict_cnt statistics counter.
module regfile_write_arbiter #(
    parameter int N        = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [N-1:0]      wb_data,
    output logic              wb_ready,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [N-1:0]      mdu_data,
    output logic              mdu_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [N-1:0]      rf_wd,
    output logic              b_forced,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {PRIO_A, FORCE_B} state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_wa_q;
    logic [N-1:0]      rf_wd_q;
    logic              accept;
    logic [ADDR_W-1:0] sel_rd;
    logic [N-1:0]      sel_data;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        wb_ready  = 1'b0;
        mdu_ready = 1'b0;
        b_forced  = 1'b0;
        case (state_q)
            PRIO_A: begin
                wb_ready  = wb_valid;
                mdu_ready = mdu_valid && !wb_valid;
                if (mdu_ready) begin
                    wait_d = 4'd0;
                end else if (mdu_valid) begin
                    if (wait_q < MAX_WAIT_C) begin
                        wait_d = wait_q + 4'd1;
                    end
                    if (wait_d == MAX_WAIT_C) begin
                        state_d = FORCE_B;
                    end
                end
            end
            FORCE_B: begin
                // A is held off for this one cycle even if B has withdrawn.
                b_forced  = 1'b1;
                mdu_ready = mdu_valid;
                wait_d    = 4'd0;
                state_d   = PRIO_A;
            end
            default: begin
                state_d = PRIO_A;
                wait_d  = 4'd0;
            end
        endcase
    end

    assign accept   = wb_ready || mdu_ready;
    assign sel_rd   = wb_ready ? wb_rd : mdu_rd;
    assign sel_data = wb_ready ? wb_data : mdu_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PRIO_A;
            wait_q  <= 4'd0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            // x0 writes are consumed but never reach the register file.
            rf_we_q <= accept && (sel_rd != '0);
            if (accept) begin
                rf_wa_q <= sel_rd;
                rf_wd_q <= sel_data;
            end
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

`ifdef RFARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 16'd0;
        end else if (wb_valid && mdu_valid && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        wb_ready;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        b_forced;
    logic [15:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .b_forced(b_forced), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: B's denial streak, pending forced slot, pending write.
    bit          m_force;
    int          m_wait;
    int          m_cnt;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;

    function automatic int stats_view(input int cnt);
`ifdef RFARB_STATS_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        bit ga, gb;
        if (reset) begin
            m_force = 0; m_wait = 0; m_cnt = 0;
            exp_we = 0; exp_wa = '0; exp_wd = '0;
            chk("rst_rf_we", rf_we, 0);
            chk("rst_rf_wa", rf_wa, 0);
            chk("rst_rf_wd", rf_wd, 0);
            chk("rst_b_forced", b_forced, 0);
            chk("rst_conflict", conflict_cnt, 0);
        end else begin
            chk("m_rf_we", rf_we, exp_we);
            chk("m_rf_wa", rf_wa, exp_wa);
            chk("m_rf_wd", rf_wd, exp_wd);
            chk("m_b_forced", b_forced, m_force);
            chk("m_conflict", conflict_cnt, stats_view(m_cnt));
            ga = m_force ? 1'b0 : wb_valid;
            gb = m_force ? mdu_valid : (mdu_valid && !wb_valid);
            chk("m_wb_ready", wb_ready, ga);
            chk("m_mdu_ready", mdu_ready, gb);
            if (m_force) begin
                m_force = 0;
                m_wait = 0;
            end else if (gb) begin
                m_wait = 0;
            end else if (mdu_valid) begin
                m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
                if (m_wait == MAX_WAIT) m_force = 1;
            end
            if (wb_valid && mdu_valid && m_cnt < 65535) m_cnt++;
            if (ga) begin
                exp_we = (wb_rd != 0); exp_wa = wb_rd; exp_wd = wb_data;
            end else if (gb) begin
                exp_we = (mdu_rd != 0); exp_wa = mdu_rd; exp_wd = mdu_data;
            end else begin
                exp_we = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wb_valid = 1'b0;
        mdu_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Both requesters contend; B must wait MAX_WAIT cycles then win once.
    task automatic conflict_run(input bit drop_b);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hA0A0_0001;
        mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_data = 32'hB0B0_0002;
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1;
            chk("cr_wb_ready", wb_ready, 1);
            chk("cr_mdu_ready", mdu_ready, 0);
            chk("cr_b_forced", b_forced, 0);
            tick();
        end
        if (drop_b) mdu_valid = 1'b0;
        #1;
        chk("cr_force_b_forced", b_forced, 1);
        chk("cr_force_wb_ready", wb_ready, 0);
        chk("cr_force_mdu_ready", mdu_ready, drop_b ? 0 : 1);
        tick();
        mdu_valid = 1'b0;
        #1;
        chk("cr_resume_wb_ready", wb_ready, 1);
        chk("cr_resume_b_forced", b_forced, 0);
    endtask

    initial begin
        logic [31:0] pat_a;
        logic [31:0] pat_b;
        bit a_acc, b_acc;

        // single A write
        do_reset();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1 chk("s1_wb_ready", wb_ready, 1);
        tick();
        wb_valid = 1'b0;
        chk("s1_rf_we", rf_we, 1);
        chk("s1_rf_wa", rf_wa, 5);
        chk("s1_rf_wd", rf_wd, 32'hDEADBEEF);
        tick();
        chk("s1_rf_we_after", rf_we, 0);

        // aging and forced grant
        do_reset();
        conflict_run(1'b0);
        chk("s2_rf_wa_b", rf_wa, 2);
        chk("s2_rf_wd_b", rf_wd, 32'hB0B0_0002);
`ifdef RFARB_STATS_EN
        chk("s2_conflict", conflict_cnt, 5);
`else
        chk("s2_conflict", conflict_cnt, 0);
`endif
        tick();
        wb_valid = 1'b0;
        tick();

        // x0 write from B
        do_reset();
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h12345678;
        #1 chk("s3_mdu_ready", mdu_ready, 1);
        tick();
        mdu_valid = 1'b0;
        chk("s3_rf_we", rf_we, 0);
        tick();

        // B withdraws in FORCE_B; counter must restart from zero
        do_reset();
        conflict_run(1'b1);
        tick();
        conflict_run(1'b0);
        tick();
        wb_valid = 1'b0;
        tick();

        // same rd from both: A then B
        do_reset();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h2;
        #1 chk("s5_wb_ready", wb_ready, 1);
        tick();
        wb_valid = 1'b0;
        #1 chk("s5_mdu_ready", mdu_ready, 1);
        chk("s5_first_we", rf_we, 1);
        chk("s5_first_wa", rf_wa, 7);
        chk("s5_first_wd", rf_wd, 32'h1);
        tick();
        mdu_valid = 1'b0;
        chk("s5_second_we", rf_we, 1);
        chk("s5_second_wa", rf_wa, 7);
        chk("s5_second_wd", rf_wd, 32'h2);
        tick();

        // reset right after an acceptance
        do_reset();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hAAAA_5555;
        tick();
        wb_valid = 1'b0;
        chk("s6_pre_we", rf_we, 1);
        reset = 1'b1;
        #1;
        chk("s6_rf_we", rf_we, 0);
        chk("s6_rf_wa", rf_wa, 0);
        chk("s6_rf_wd", rf_wd, 0);
        chk("s6_b_forced", b_forced, 0);
        chk("s6_conflict", conflict_cnt, 0);
        tick();
        tick();
        reset = 1'b0;

        // mixed traffic, requests held until accepted
        pat_a = 32'hF0F3_6E9B;
        pat_b = 32'hFF3C_1E77;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            a_acc = wb_valid && wb_ready;
            b_acc = mdu_valid && mdu_ready;
            tick();
            if (!wb_valid || a_acc) begin
                wb_valid = pat_a[i];
                wb_rd = 5'(i * 3);
                wb_data = $urandom;
            end
            if (!mdu_valid || b_acc) begin
                mdu_valid = pat_b[i];
                mdu_rd = 5'(i * 5 + 1);
                mdu_data = $urandom;
            end
        end
        @(negedge clk);
        a_acc = wb_valid && wb_ready;
        b_acc = mdu_valid && mdu_ready;
        tick();
        if (a_acc) wb_valid = 1'b0;
        if (b_acc) mdu_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            a_acc = wb_valid && wb_ready;
            b_acc = mdu_valid && mdu_ready;
            tick();
            if (a_acc) wb_valid = 1'b0;
            if (b_acc) mdu_valid = 1'b0;
        end
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
